sync_dual_port_ram: RTL and testbench

//  Single-clock simple dual-port RAM (one write port, one read port) for on-chip buffers and caches.

---
 rtl/memory_pkg.sv | 36 +++
 rtl/ram_clear_sequencer.sv | 68 ++++++
 rtl/sync_dual_port_ram.sv | 138 +++++++++++++
 tb/tb_sync_dual_port_ram.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the on-chip RAM family: clear-sequencer state encodings,
// latency limits and the byte-lane merge used by the write-first bypass.
package memory_pkg;

  localparam int unsigned MAX_READ_LATENCY = 2;
  localparam int unsigned MAX_WORD_SIZE    = 512;
  localparam int unsigned MAX_LANES        = 64;

  typedef enum logic [0:0] {
    RAM_STATE_IDLE  = 1'b0,
    RAM_STATE_CLEAR = 1'b1
  } ram_state_e;

  typedef logic [MAX_WORD_SIZE-1:0] word_t;
  typedef logic [MAX_LANES-1:0]     lane_mask_t;

  // Lanes with mask=1 take new_word, the rest keep old_word; callers zero-extend and truncate.
  function automatic word_t merge_lanes(input word_t      old_word,
                                        input word_t      new_word,
                                        input lane_mask_t mask,
                                        input int unsigned byte_width);
    word_t      lane_ones;
    word_t      bits;
    lane_mask_t shifted;
    lane_ones = ~(~word_t'(0) << byte_width);
    bits      = '0;
    for (int unsigned l = 0; l < MAX_LANES; l++) begin
      shifted = mask >> l;
      if (shifted[0]) begin
        bits = bits | (lane_ones << (l * byte_width));
      end
    end
    return (old_word & ~bits) | (new_word & bits);
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Post-reset zero-fill sequencer: walks every entry once, holding the RAM busy
// until the last entry has been written.
module ram_clear_sequencer
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  clear_en
);

  localparam ram_state_e            RESET_STATE = CLEAR_ON_RESET ? RAM_STATE_CLEAR : RAM_STATE_IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

  ram_state_e            state;
  ram_state_e            state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_next;
  logic                  busy_next;
  logic                  clear_en_next;

  // clear_en resets high so the first edge after reset already writes entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_STATE;
      count    <= '0;
      busy     <= 1'b1;
      clear_en <= CLEAR_ON_RESET;
    end else begin
      state    <= state_next;
      count    <= count_next;
      busy     <= busy_next;
      clear_en <= clear_en_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    busy_next     = 1'b0;
    clear_en_next = 1'b0;
    case (state)
      RAM_STATE_CLEAR: begin
        busy_next     = 1'b1;
        clear_en_next = 1'b1;
        if (count == LAST_ADDR) begin
          state_next    = RAM_STATE_IDLE;
          count_next    = '0;
          busy_next     = 1'b0;
          clear_en_next = 1'b0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      RAM_STATE_IDLE: begin
        busy_next = 1'b0;
      end
    endcase
  end

  assign clear_addr = count;

endmodule

// File: rtl/sync_dual_port_ram.sv
// Single-clock simple dual-port RAM with byte-lane writes, write-first collision
// bypass, 1- or 2-cycle read latency and an optional zero sweep after reset.
module sync_dual_port_ram
  import memory_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH),
  localparam int unsigned LANES         = WORD_SIZE / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [LANES-1:0]      write_mask,
  input  logic [WORD_SIZE-1:0]  write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WORD_SIZE-1:0]  read_data,
  output logic                  read_valid
);

  localparam bit                    FULL_RANGE = (32'd1 << ADDR_WIDTH) == DEPTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("sync_dual_port_ram: READ_LATENCY must be 1 or 2");
  end
  if (BYTE_WIDTH == 0 || (WORD_SIZE % BYTE_WIDTH) != 0) begin : g_bad_lanes
    $error("sync_dual_port_ram: WORD_SIZE must be a multiple of BYTE_WIDTH");
  end
  if (WORD_SIZE > MAX_WORD_SIZE || LANES > MAX_LANES) begin : g_bad_width
    $error("sync_dual_port_ram: word too wide for merge_lanes");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_dual_port_ram: DEPTH must be at least 2");
  end

  logic [WORD_SIZE-1:0]  mem [DEPTH];

  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  clear_en;
  logic                  port_open_c;
  logic                  write_in_range_c;
  logic                  read_in_range_c;
  logic                  clear_wr_c;
  logic                  write_fire_c;
  logic                  read_fire_c;
  logic [LANES-1:0]      bypass_mask_c;
  logic                  s1_valid;
  logic [WORD_SIZE-1:0]  s1_data;

  ram_clear_sequencer #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_sequencer (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .clear_addr (clear_addr),
    .clear_en   (clear_en)
  );

  // A power-of-two depth makes every address legal, so skip the compare
  if (FULL_RANGE) begin : g_full_range
    assign write_in_range_c = 1'b1;
    assign read_in_range_c  = 1'b1;
  end else begin : g_partial_range
    assign write_in_range_c = write_addr <= LAST_ADDR;
    assign read_in_range_c  = read_addr <= LAST_ADDR;
  end

  assign port_open_c   = !rst && !busy;
  assign clear_wr_c    = clear_en && !rst;
  assign write_fire_c  = port_open_c && write_en && write_in_range_c && (write_mask != '0);
  assign read_fire_c   = port_open_c && read_en;
  assign bypass_mask_c = (write_fire_c && (write_addr == read_addr)) ? write_mask : '0;

  // Write port: clear sweep has priority (user port is closed while it runs)
  always_ff @(posedge clk) begin
    if (clear_wr_c) begin
      mem[clear_addr] <= '0;
    end else if (write_fire_c) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (write_mask[l]) begin
          mem[write_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read port stage 1: same-edge write lanes are forwarded over the stored word
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read_fire_c;
      if (read_fire_c) begin
        if (read_in_range_c) begin
          s1_data <= WORD_SIZE'(merge_lanes(word_t'(mem[read_addr]),
                                            word_t'(write_data),
                                            lane_mask_t'(bypass_mask_c),
                                            BYTE_WIDTH));
        end else begin
          s1_data <= '0;
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_latency2
    logic                 s2_valid;
    logic [WORD_SIZE-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
      end
    end

    assign read_valid = s2_valid;
    assign read_data  = s2_data;
  end else begin : g_latency1
    assign read_valid = s1_valid;
    assign read_data  = s1_data;
  end

endmodule

// File: tb/tb_sync_dual_port_ram.sv
// Bench for sync_dual_port_ram: two instances (256 deep / latency 1, 200 deep / latency 2)
// share one stimulus stream; a reference memory model feeds a scoreboard checked at negedge.
module tb_sync_dual_port_ram;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic [7:0]  write_addr = '0;
  logic [3:0]  write_mask = '0;
  logic [31:0] write_data = '0;
  logic        read_en = 1'b0;
  logic [7:0]  read_addr = '0;

  logic        busy_a, busy_b, rv_a, rv_b;
  logic [31:0] rd_a, rd_b;

  wire  [1:0]  busy_v = {busy_b, busy_a};
  wire  [1:0]  rv_v   = {rv_b, rv_a};
  logic [31:0] rd_v [2];
  assign rd_v[0] = rd_a;
  assign rd_v[1] = rd_b;

  sync_dual_port_ram #(
    .WORD_SIZE(32), .BYTE_WIDTH(8), .DEPTH(256), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .busy(busy_a),
    .write_en(write_en), .write_addr(write_addr), .write_mask(write_mask), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(rd_a), .read_valid(rv_a)
  );

  sync_dual_port_ram #(
    .WORD_SIZE(32), .BYTE_WIDTH(8), .DEPTH(200), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .busy(busy_b),
    .write_en(write_en), .write_addr(write_addr), .write_mask(write_mask), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(rd_b), .read_valid(rv_b)
  );

  always #5 clk = ~clk;

  int unsigned depth [2] = '{256, 200};
  int unsigned lat   [2] = '{1, 2};
  int unsigned sweep_n [2] = '{0, 0};
  logic [31:0] ref_mem [2][256];
  logic [31:0] last [2] = '{32'h0, 32'h0};
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];

  function automatic int q_size(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic void q_push(input int d, input exp_t e);
    if (d == 0) q_a.push_back(e); else q_b.push_back(e);
  endfunction

  function automatic exp_t q_pop(input int d);
    return (d == 0) ? q_a.pop_front() : q_b.pop_front();
  endfunction

  function automatic exp_t q_front(input int d);
    return (d == 0) ? q_a[0] : q_b[0];
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, d, act, want, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs the DUTs just sampled
  function automatic void model_edge();
    exp_t e;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sweep_n[d] = 0;
        last[d] = 32'h0;
        if (d == 0) q_a.delete(); else q_b.delete();
        for (int a = 0; a < 256; a++) ref_mem[d][a] = 32'h0;
      end else if (sweep_n[d] < depth[d]) begin
        sweep_n[d]++;
      end else begin
        if (write_en && 32'(write_addr) < depth[d]) begin
          for (int l = 0; l < 4; l++) begin
            if (write_mask[l]) ref_mem[d][write_addr][8*l +: 8] = write_data[8*l +: 8];
          end
        end
        if (read_en) begin
          e.data = (32'(read_addr) < depth[d]) ? ref_mem[d][read_addr] : 32'h0;
          e.due  = cyc + lat[d] - 1;
          q_push(d, e);
        end
      end
    end
  endfunction

  task automatic drive(input logic we, input logic [7:0] wa, input logic [3:0] wm,
                       input logic [31:0] wd, input logic re, input logic [7:0] ra);
    write_en = we; write_addr = wa; write_mask = wm; write_data = wd;
    read_en = re; read_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0);
  endtask

  // Directed check of the next result on one instance, bounded to a few cycles
  task automatic expect_rd(input int d, input logic [31:0] want, input string name);
    int n = 0;
    while (!rv_v[d] && n < 4) begin
      idle(1);
      n++;
    end
    chk({name, "_valid"}, d, 32'(rv_v[d]), 32'h1);
    if (rv_v[d]) chk(name, d, rd_v[d], want);
  endtask

  // Count busy cycles after reset release while firing reads that must be dropped
  task automatic sweep_and_count(input string name);
    int cnt_a = 0;
    int cnt_b = 0;
    int n = 0;
    while ((busy_a || busy_b) && n < 600) begin
      cnt_a += int'(busy_a);
      cnt_b += int'(busy_b);
      drive(1'b1, 8'($urandom), 4'hF, $urandom, 1'b1, 8'($urandom));
      n++;
    end
    chk({name, "_busy_len"}, 0, 32'(cnt_a), 32'd256);
    chk({name, "_busy_len"}, 1, 32'(cnt_b), 32'd200);
    idle(3);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      chk("busy", d, 32'(busy_v[d]), 32'(sweep_n[d] < depth[d]));
      if (rv_v[d]) begin
        if (q_size(d) == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid dut%0d actual=1 required=0 t=%0t", d, $time);
        end else begin
          e = q_pop(d);
          chk("latency", d, cyc, e.due);
          chk("read_data", d, rd_v[d], e.data);
          last[d] = e.data;
        end
      end else begin
        if (q_size(d) != 0 && q_front(d).due <= cyc) begin
          e = q_pop(d);
          total++;
          bad++;
          $display("FAIL missing_valid dut%0d actual=0 required=1 data=%h t=%0t", d, e.data, $time);
        end
        chk("read_hold", d, rd_v[d], last[d]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog dut0 actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wa;
    logic [7:0] ra;

    // Reset for three cycles, then the clear sweep
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    sweep_and_count("clear");
    foreach (depth[i]) begin end
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd0);
    expect_rd(0, 32'h0, "clear_rd0"); expect_rd(1, 32'h0, "clear_rd0");
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd17);
    expect_rd(0, 32'h0, "clear_rd17"); expect_rd(1, 32'h0, "clear_rd17");
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd255);
    expect_rd(0, 32'h0, "clear_rd255"); expect_rd(1, 32'h0, "clear_rd255");
    idle(2);

    // Byte-lane writes
    drive(1'b1, 8'd5, 4'hF, 32'hAABBCCDD, 1'b0, 8'h0);
    drive(1'b1, 8'd5, 4'b0101, 32'h11223344, 1'b0, 8'h0);
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd5);
    expect_rd(0, 32'hAA22CC44, "lane_merge"); expect_rd(1, 32'hAA22CC44, "lane_merge");
    idle(2);

    // Write-first collision on a zeroed entry
    drive(1'b1, 8'd9, 4'b0011, 32'hDEADBEEF, 1'b1, 8'd9);
    expect_rd(0, 32'h0000BEEF, "collision"); expect_rd(1, 32'h0000BEEF, "collision");
    idle(2);

    // Out-of-range write and reads
    drive(1'b1, 8'd210, 4'hF, 32'h12345678, 1'b0, 8'h0);
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd210);
    expect_rd(0, 32'h12345678, "oor_rd210"); expect_rd(1, 32'h0, "oor_rd210");
    idle(2);
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd10);
    expect_rd(0, 32'h0, "oor_rd10"); expect_rd(1, 32'h0, "oor_rd10");
    idle(2);

    // Streaming reads of addrs 0..7 after filling them
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 4'hF, {8'(i), 24'($urandom)}, 1'b0, 8'h0);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'(i));
    idle(4);

    // Random traffic, biased toward a small address window so collisions happen
    for (int i = 0; i < 1500; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa
         : (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
      drive(1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom), ra);
    end
    idle(3);

    // Reset in the middle of a sweep restarts it from entry 0
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) drive(1'b1, 8'($urandom), 4'hF, $urandom, 1'b1, 8'($urandom));
    rst = 1'b1;
    drive(1'b1, 8'd3, 4'hF, 32'hCAFEF00D, 1'b1, 8'd3);
    drive(1'b1, 8'd3, 4'hF, 32'hCAFEF00D, 1'b1, 8'd3);
    rst = 1'b0;
    sweep_and_count("restart");
    drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'd3);
    expect_rd(0, 32'h0, "restart_rd3"); expect_rd(1, 32'h0, "restart_rd3");

    // Short random burst after the restarted sweep
    for (int i = 0; i < 300; i++) begin
      wa = 8'($urandom_range(190, 215));
      ra = ($urandom_range(0, 1) == 0) ? wa : 8'($urandom_range(190, 215));
      drive(1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom), ra);
    end
    idle(5);
    chk("drain", 0, 32'(q_size(0)), 32'd0);
    chk("drain", 1, 32'(q_size(1)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
